uart_rx: RTL
============

Name: uart_rx

Overview:
- 8N1 UART receiver that deserialises the asynchronous serial line into bytes.
- Sits directly upstream of the receive FIFO controller and drives its `rx_ready`/`data` inputs.
- Each completed, error-free frame produces a one-cycle `rx_ready` pulse, with `data` held stable until the next good frame completes.
- Counter-based bit timing with mid-bit sampling; no external baud tick.

Parameters:
- CLKS_PER_BIT, 5208, clk cycles per bit (50 MHz / 9600 baud); must be >= 4; minimum 4 is for simulation only.
- PARITY_ODD, 0, parity sense when UART_RX_PARITY_EN is defined (0 = even, 1 = odd); ignored otherwise.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- rx  input  1  asynchronous serial line, idle high
- data  output  8  last good received byte, LSB received first
- rx_ready  output  1  one-cycle pulse: new byte valid on data
- frame_err  output  1  high if the last completed frame had stop bit = 0
- busy  output  1  high while in any state other than IDLE
- parity_err  output  1  present only with UART_RX_PARITY_EN

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high, sampled on the rising edge of `clk`.
- Reset values:
  - data = 8'h00, rx_ready = 0, frame_err = 0, busy = 0, parity_err = 0.
  - State = IDLE; internal counters cleared; synchroniser flops = 1.
  - A reset asserted mid-frame abandons the frame with no `rx_ready`.
- Synchroniser: `rx` passes through 2 flops to give `rx_s`. All decisions use `rx_s`.
- `clk_cnt` width is ceil(log2(CLKS_PER_BIT)) bits; `bit_idx` is 3 bits.
- State machine:
  - IDLE: when `rx_s` = 0, go to START with clk_cnt = 0.
  - START: increment clk_cnt. At clk_cnt == CLKS_PER_BIT/2 - 1 (integer division):
    - if `rx_s` = 0, go to DATA with clk_cnt = 0 and bit_idx = 0;
    - else treat as a glitch and return to IDLE (no output change).
  - DATA: at clk_cnt == CLKS_PER_BIT - 1:
    - shift `rx_s` into the shift register at bit position bit_idx (LSB first) and clear clk_cnt;
    - after bit_idx == 7, go to STOP (or PARITY with the macro defined).
  - STOP: at clk_cnt == CLKS_PER_BIT - 1, sample `rx_s`:
    - if 1: data <= shift register; rx_ready = 1 for exactly the next cycle; frame_err <= 0; go to IDLE.
    - if 0: frame_err <= 1; data unchanged; no rx_ready; go to WAIT_IDLE.
  - WAIT_IDLE: stay until `rx_s` = 1, then go to IDLE. This covers a break or stuck-low line, which must not retrigger START.
- Timing:
  - rx_ready is never high on two consecutive cycles.
  - The minimum spacing between rx_ready pulses is 9.5 bit periods.
  - data changes only in the same cycle that rx_ready rises.
  - Latency from the `rx` falling edge to the rx_ready high cycle is 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 clk, ±1 clk (synchroniser phase).
- Back-to-back frames: returning to IDLE at mid-stop-bit lets a start bit immediately following the stop bit be detected without loss.
- frame_err is a level. It updates only at the STOP sample and holds until the next STOP sample.

Optional Feature:
- UART_RX_PARITY_EN:
  - A PARITY state is inserted between DATA and STOP; the parity bit is sampled at clk_cnt == CLKS_PER_BIT - 1.
  - parity_err <= (XOR of the 8 data bits and the parity bit) != PARITY_ODD.
  - The STOP behaviour is unchanged, except that rx_ready and the data update occur only if the stop bit = 1 and parity is good. A bad-parity frame is dropped, so it never reaches the FIFO.
  - parity_err holds until the next parity sample.
- Without the macro: 8N1 only; no PARITY state; no parity_err port.

Test Plan:
- All scenarios use CLKS_PER_BIT = 16.
- Reset, then idle `rx` = 1 for 100 clk -> busy = 0, rx_ready never asserted, data = 8'h00.
- Send 0xA5 (start, 1,0,1,0,0,1,0,1, stop = 1) -> exactly one rx_ready pulse, data = 8'hA5, frame_err = 0, pulse at the specified latency ±1.
- Send 0x00 then 0xFF back-to-back with no idle gap -> two rx_ready pulses 160 clk apart, data = 8'h00 then 8'hFF.
- Drive `rx` low for 4 clk, then high -> return to IDLE, no rx_ready, busy low again within 10 clk.
- Send 0x3C with stop bit = 0 and hold `rx` low 64 clk -> frame_err = 1, no rx_ready, data keeps the previous value, busy stays high until `rx` rises; then a good 0x3C gives frame_err = 0 and data = 8'h3C.
- Assert rst mid-DATA of a 0x55 frame, release, then send 0x81 -> no pulse for 0x55, data = 8'h81. With UART_RX_PARITY_EN and PARITY_ODD = 0, 0x81 with parity bit 1 -> parity_err = 1 and no rx_ready.

Source files
------------

// File: rtl/uart_rx_if.sv
// Receive-side bus of the 8N1 UART: serial line in, byte/status out toward the RX FIFO controller.
// With UART_RX_PARITY_EN defined the bus also carries parity_err.
interface uart_rx_if;
  logic       rx;
  logic [7:0] data;
  logic       rx_ready;
  logic       frame_err;
  logic       busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;

  modport master (input rx, output data, output rx_ready, output frame_err, output busy,
                  output parity_err);
  modport slave  (output rx, input data, input rx_ready, input frame_err, input busy,
                  input parity_err);
`else
  modport master (input rx, output data, output rx_ready, output frame_err, output busy);
  modport slave  (output rx, input data, input rx_ready, input frame_err, input busy);
`endif
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, counter-based mid-bit sampling, one-cycle rx_ready per good frame.
// Define UART_RX_PARITY_EN to insert a parity bit (sense set by PARITY_ODD) between data and stop.
module uart_rx #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int PARITY_ODD   = 0
) (
  input  logic      clk,
  input  logic      rst,
  uart_rx_if.master bus
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;
`endif

  state_t           state, state_nxt;
  logic             rx_p0, rx_p1, rx_s;
  logic [CNT_W-1:0] clk_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       sr;
  logic [7:0]       data_q;
  logic             rx_ready_q, frame_err_q, parity_err_q;
  logic             half_hit, bit_hit;
  logic             busy, cnt_clr, idx_clr, shift_en, stop_smp, par_smp, par_ok;

  // Stage p0/p1: synchronise the asynchronous line; everything downstream uses rx_s
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
    end else begin
      rx_p0 <= bus.rx;
      rx_p1 <= rx_p0;
    end
  end

  assign rx_s     = rx_p1;
  assign half_hit = (clk_cnt == HALF_LAST);
  assign bit_hit  = (clk_cnt == BIT_LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (!rx_s) state_nxt = START;
      START:     if (half_hit) state_nxt = rx_s ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
      DATA:      if (bit_hit && bit_idx == 3'd7) state_nxt = PARITY;
      PARITY:    if (bit_hit) state_nxt = STOP;
`else
      DATA:      if (bit_hit && bit_idx == 3'd7) state_nxt = STOP;
`endif
      STOP:      if (bit_hit) state_nxt = rx_s ? IDLE : WAIT_IDLE;
      WAIT_IDLE: if (rx_s) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != IDLE);
    idx_clr  = (state == START);
    shift_en = (state == DATA) && bit_hit;
    stop_smp = (state == STOP) && bit_hit;
    par_smp  = 1'b0;
    cnt_clr  = 1'b0;
    case (state)
      IDLE, WAIT_IDLE: cnt_clr = 1'b1;
      START:           cnt_clr = half_hit;
      default:         cnt_clr = bit_hit;
    endcase
`ifdef UART_RX_PARITY_EN
    par_smp  = (state == PARITY) && bit_hit;
`endif
  end

`ifdef UART_RX_PARITY_EN
  // parity_err is updated one bit period before the stop sample, so it already reflects this frame
  assign par_ok = !parity_err_q;
`else
  assign par_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (shift_en) sr[bit_idx] <= rx_s;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_cnt      <= '0;
      bit_idx      <= 3'd0;
      data_q       <= 8'h00;
      rx_ready_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      clk_cnt    <= cnt_clr ? '0 : clk_cnt + CNT_W'(1);
      rx_ready_q <= stop_smp && rx_s && par_ok;
      if (idx_clr)       bit_idx <= 3'd0;
      else if (shift_en) bit_idx <= bit_idx + 3'd1;
      if (stop_smp) begin
        frame_err_q <= !rx_s;
        if (rx_s && par_ok) data_q <= sr;
      end
      if (par_smp) parity_err_q <= (((^sr) ^ rx_s) != 1'(PARITY_ODD));
    end
  end

  assign bus.data      = data_q;
  assign bus.rx_ready  = rx_ready_q;
  assign bus.frame_err = frame_err_q;
  assign bus.busy      = busy;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err = parity_err_q;
`endif

endmodule
